vector_execute_stage: RTL and testbench
=======================================

Name: vector_execute_stage

Overview:
Execute stage of the vectorial ASIP pipeline. It applies one element-wise ALU operation across all lanes of two operand vectors. The result goes out combinationally to the memory/writeback stage. The stage also keeps a registered pair of condition flags (negative, zero) that later branch instructions use.

Parameters:
vectorSize, 4, number of lanes per vector
registerSize, 8, bit width of each lane

Ports:
clk  input  1  pipeline clock; all state updates on its rising edge
reset  input  1  asynchronous, active-low reset
ExecuteOp  input  3  operation select (encoding below)
PCWrEn  input  1  current instruction writes the PC (branch); suppresses flag update
overwriteFlags  input  1  current instruction is allowed to update NZ_flags
vect1  input  vectorSize x registerSize  first operand, packed; lane i = vect1[i]
vect2  input  vectorSize x registerSize  second operand or per-lane shift amount, packed
vect_out  output  vectorSize x registerSize  per-lane result, combinational
NZ_flags  output  2  registered flags; bit1 = Z, bit0 = N

Behaviour:
- Lanes are independent. Lane i result is r[i] = f(vect1[i], vect2[i]). All arithmetic is unsigned modulo 2^registerSize; carries and borrows are discarded.
- Opcode 000, MOV: r = vect2.
- Opcode 001, XOR: r = a ^ b.
- Opcode 010, ADD: r = (a + b) mod 2^W. Example: 0xCC + 0xF0 = 0xBC.
- Opcode 011, SUB: r = (a - b) mod 2^W. Example: 0x55 - 0xAA = 0xAB.
- Opcode 100, MUL: r = low W bits of a*b.
- Opcode 101, SHR: logical right shift of a by b[$clog2(W)-1:0]. Zero fill. Upper bits of b are ignored.
- Opcode 110, SHL: logical left shift of a by the same shift amount. Zero fill; bits shifted out are lost.
- Opcode 111, PASS: r = vect1.
- vect_out is purely combinational from ExecuteOp, vect1 and vect2. It has zero latency and is not affected by reset.
- Next-flag value from the current vect_out:
  - Z = 1 iff every lane of vect_out is 0.
  - N = OR of the MSBs of all lanes.
  - N and Z can never both be 1.
- Flag register write enable = overwriteFlags & ~PCWrEn.
  - On a rising clk edge with the enable high, NZ_flags <= {Z, N}.
  - Otherwise NZ_flags holds its value.
- Flag latency: NZ_flags reflects an operation one cycle after the operation is presented.
- Reset: reset low forces NZ_flags = 2'b00 immediately, asynchronously. While reset is low, flag updates are ignored. On release, the first update happens at the next qualifying edge.
- Reset asserted mid-operation: flags clear; vect_out continues to follow its inputs.

Optional Feature:
Macro EXEC_SATURATE_EN.
- Defined: ADD clamps to 2^W-1 on carry, and SUB clamps to 0 on borrow. Example: 0xCC+0xF0=0xFF, 0x55-0xAA=0x00. Flags are computed from the clamped result.
- Undefined: ADD and SUB wrap modulo 2^W as specified above.
- All other opcodes are unchanged either way.

Decomposition:
- Shared package: 3-bit opcode enum (OP_MOV, OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_SHR, OP_SHL, OP_PASS) and flag bit index constants (FLAG_Z=1, FLAG_N=0).
- One sub-module, vector_lane_alu: a single-lane combinational ALU parameterised by registerSize. It is instantiated vectorSize times with a generate loop.
- The flag logic and flag register live in the top module.

Test Plan:
- Reset: reset low with clk running -> NZ_flags=00. Release reset, then drive a SUB with vect1==vect2={0x33,0xCC,0xAA,0x55}, overwriteFlags=1, PCWrEn=0 -> vect_out all 0; NZ_flags=10 after one edge.
- XOR, then ADD: vect1={0x33,0xCC,0xAA,0x55}, vect2={0x0F,0xF0,0x55,0xAA}.
  - XOR -> {0x3C,0x3C,0xFF,0xFF}, NZ=01.
  - ADD -> {0x42,0xBC,0xFF,0xFF}, NZ=01.
- SUB with the same operands -> {0x24,0xDC,0x55,0xAB}, NZ=01. MUL with vect1={3,12,10,5}, vect2={15,0,5,10} -> {0x2D,0x00,0x32,0x32}, NZ=00.
- Shifts with vect1={0xAA,0x55,0xF0,0x0F}, vect2={1,2,3,4}:
  - SHR -> {0x55,0x15,0x1E,0x00}, NZ=00.
  - SHL -> {0x54,0x54,0x80,0xF0}, NZ=01.
- Flag gating: after NZ=10, apply XOR giving 0xFF lanes with PCWrEn=1 -> NZ stays 10. Repeat with PCWrEn=0, overwriteFlags=0 -> NZ stays 10. Repeat with overwriteFlags=1 -> NZ=01.
- MOV/PASS and asynchronous reset: MOV -> vect_out==vect2; PASS -> vect_out==vect1. Pulse reset low between clock edges -> NZ_flags clears without waiting for an edge.

Source files
------------

// File: rtl/vector_execute_stage_pkg.sv
// Shared definitions for the vector execute stage: opcode encoding and flag bit positions.
package vector_execute_stage_pkg;

    typedef enum logic [2:0] {
        OP_MOV  = 3'b000,
        OP_XOR  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MUL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_SHL  = 3'b110,
        OP_PASS = 3'b111
    } opcode_e;

    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_N = 0;

endpackage

// File: rtl/vector_lane_alu.sv
// Single-lane combinational ALU of the vector execute stage.
// EXEC_SATURATE_EN selects saturating ADD/SUB instead of modulo wrap.
module vector_lane_alu
    import vector_execute_stage_pkg::*;
#(
    parameter int registerSize = 8
) (
    input  opcode_e                 op,
    input  logic [registerSize-1:0] a,
    input  logic [registerSize-1:0] b,
    output logic [registerSize-1:0] result
);

    localparam int SHW = (registerSize > 1) ? $clog2(registerSize) : 1;

    logic [SHW-1:0]          shamt;
    logic [registerSize-1:0] prod;

`ifdef EXEC_SATURATE_EN
    // Extra bit holds the carry/borrow used for clamping.
    logic [registerSize:0] sum;
    logic [registerSize:0] diff;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
`else
    logic [registerSize-1:0] sum;
    logic [registerSize-1:0] diff;
    assign sum  = a + b;
    assign diff = a - b;
`endif

    assign prod  = a * b;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            OP_MOV:  result = b;
            OP_XOR:  result = a ^ b;
`ifdef EXEC_SATURATE_EN
            OP_ADD:  result = sum[registerSize]  ? '1 : sum[registerSize-1:0];
            OP_SUB:  result = diff[registerSize] ? '0 : diff[registerSize-1:0];
`else
            OP_ADD:  result = sum;
            OP_SUB:  result = diff;
`endif
            OP_MUL:  result = prod;
            OP_SHR:  result = a >> shamt;
            OP_SHL:  result = a << shamt;
            OP_PASS: result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/vector_execute_stage.sv
// Execute stage of the vector ASIP: per-lane ALU plus registered N/Z branch flags.
// Optional macro EXEC_SATURATE_EN makes ADD/SUB saturate (handled in vector_lane_alu).
module vector_execute_stage
    import vector_execute_stage_pkg::*;
#(
    parameter int vectorSize   = 4,
    parameter int registerSize = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [2:0]                         ExecuteOp,
    input  logic                               PCWrEn,
    input  logic                               overwriteFlags,
    input  logic [vectorSize*registerSize-1:0] vect1,
    input  logic [vectorSize*registerSize-1:0] vect2,
    output logic [vectorSize*registerSize-1:0] vect_out,
    output logic [1:0]                         NZ_flags
);

    opcode_e               op;
    logic [vectorSize-1:0] lane_msb;
    logic                  flag_z;
    logic                  flag_n;
    logic                  flag_we;

    assign op = opcode_e'(ExecuteOp);

    for (genvar i = 0; i < vectorSize; i++) begin : g_lane
        vector_lane_alu #(
            .registerSize(registerSize)
        ) u_alu (
            .op    (op),
            .a     (vect1[i*registerSize +: registerSize]),
            .b     (vect2[i*registerSize +: registerSize]),
            .result(vect_out[i*registerSize +: registerSize])
        );
        assign lane_msb[i] = vect_out[i*registerSize + registerSize - 1];
    end

    // An all-zero result has no MSB set, so N and Z are mutually exclusive by construction.
    assign flag_z  = ~|vect_out;
    assign flag_n  = |lane_msb;
    assign flag_we = overwriteFlags & ~PCWrEn;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            NZ_flags <= '0;
        end else if (flag_we) begin
            NZ_flags[FLAG_Z] <= flag_z;
            NZ_flags[FLAG_N] <= flag_n;
        end
    end

endmodule

// File: tb/tb_vector_execute_stage.sv
// Scoreboard bench for vector_execute_stage: expected lane results and flags are queued at drive time.
module tb_vector_execute_stage;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic           clk;
    logic           reset;
    logic [2:0]     ExecuteOp;
    logic           PCWrEn;
    logic           overwriteFlags;
    logic [N*W-1:0] vect1;
    logic [N*W-1:0] vect2;
    logic [N*W-1:0] vect_out;
    logic [1:0]     NZ_flags;

    int vectors;
    int miscompares;

    logic [N*W-1:0] out_q[$];
    logic [1:0]     flag_q[$];
    logic [1:0]     flag_model;

    vector_execute_stage #(
        .vectorSize  (N),
        .registerSize(W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ExecuteOp     (ExecuteOp),
        .PCWrEn        (PCWrEn),
        .overwriteFlags(overwriteFlags),
        .vect1         (vect1),
        .vect2         (vect2),
        .vect_out      (vect_out),
        .NZ_flags      (NZ_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [N*W-1:0] model(input logic [2:0] op,
                                             input logic [N*W-1:0] a,
                                             input logic [N*W-1:0] b);
        logic [N*W-1:0] r;
        int ai, bi, x;
        r = '0;
        for (int i = 0; i < N; i++) begin
            ai = int'(a[i*W +: W]);
            bi = int'(b[i*W +: W]);
            case (op)
                3'd0: x = bi;
                3'd1: x = ai ^ bi;
                3'd2: begin
                    x = ai + bi;
`ifdef EXEC_SATURATE_EN
                    if (x > MASK) x = MASK;
`endif
                end
                3'd3: begin
                    x = ai - bi;
`ifdef EXEC_SATURATE_EN
                    if (x < 0) x = 0;
`endif
                end
                3'd4: x = ai * bi;
                3'd5: x = ai >> (bi % W);
                3'd6: x = ai << (bi % W);
                default: x = ai;
            endcase
            x = x & MASK;
            r[i*W +: W] = x[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [1:0] model_flags(input logic [N*W-1:0] r);
        logic z, n;
        int lane;
        z = 1'b1;
        n = 1'b0;
        for (int i = 0; i < N; i++) begin
            lane = int'(r[i*W +: W]);
            if (lane != 0) z = 1'b0;
            if (lane >= (1 << (W - 1))) n = 1'b1;
        end
        return {z, n};
    endfunction

    // Drives one operation at the falling edge and queues the expected result and post-edge flags.
    task automatic drive_op(input logic [2:0] op, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                            input logic ow, input logic pcw);
        logic [N*W-1:0] r;
        @(negedge clk);
        ExecuteOp      = op;
        vect1          = a;
        vect2          = b;
        overwriteFlags = ow;
        PCWrEn         = pcw;
        r = model(op, a, b);
        out_q.push_back(r);
        if (reset && ow && !pcw) flag_model = model_flags(r);
        flag_q.push_back(flag_model);
    endtask

    task automatic test_reset();
        logic [N*W-1:0] eo;
        logic [1:0]     ef;
        reset = 1'b0;
        flag_model = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (NZ_flags !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_state NZ_flags got %b want 00", NZ_flags);
        end
        // qualifying op while in reset must not update the flags
        drive_op(3'd3, 32'h33CCAA55, 32'h33CCAA55, 1'b1, 1'b0);
        @(posedge clk); #1;
        eo = out_q.pop_front();
        ef = flag_q.pop_front();
        vectors++;
        if (NZ_flags !== ef) begin
            miscompares++;
            $display("FAIL reset_hold NZ_flags got %b want %b", NZ_flags, ef);
        end
        vectors++;
        if (vect_out !== eo) begin
            miscompares++;
            $display("FAIL reset_vect_out got %h want %h", vect_out, eo);
        end
        @(negedge clk);
        reset = 1'b1;
        drive_op(3'd3, 32'h33CCAA55, 32'h33CCAA55, 1'b1, 1'b0);
        #1;
        eo = out_q.pop_front();
        vectors++;
        if (vect_out !== eo || vect_out !== 32'h0) begin
            miscompares++;
            $display("FAIL sub_equal vect_out got %h want %h", vect_out, eo);
        end
        @(posedge clk); #1;
        ef = flag_q.pop_front();
        vectors++;
        if (NZ_flags !== ef || NZ_flags !== 2'b10) begin
            miscompares++;
            $display("FAIL sub_equal_flags NZ_flags got %b want %b", NZ_flags, ef);
        end
    endtask

    task automatic test_arith();
        logic [2:0]     ops[4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [N*W-1:0] as[4]  = '{32'h33CCAA55, 32'h33CCAA55, 32'h33CCAA55, 32'h030C0A05};
        logic [N*W-1:0] bs[4]  = '{32'h0FF055AA, 32'h0FF055AA, 32'h0FF055AA, 32'h0F00050A};
        logic [N*W-1:0] eo;
        logic [1:0]     ef;
        for (int i = 0; i < 4; i++) begin
            drive_op(ops[i], as[i], bs[i], 1'b1, 1'b0);
            #1;
            eo = out_q.pop_front();
            vectors++;
            if (vect_out !== eo) begin
                miscompares++;
                $display("FAIL arith_op%0d vect_out got %h want %h", ops[i], vect_out, eo);
            end
            @(posedge clk); #1;
            ef = flag_q.pop_front();
            vectors++;
            if (NZ_flags !== ef) begin
                miscompares++;
                $display("FAIL arith_op%0d_flags NZ_flags got %b want %b", ops[i], NZ_flags, ef);
            end
        end
    endtask

    task automatic test_shifts();
        logic [2:0]     ops[3] = '{3'd5, 3'd6, 3'd5};
        logic [N*W-1:0] bs[3]  = '{32'h01020304, 32'h01020304, 32'h090A0BFC};
        logic [N*W-1:0] eo;
        logic [1:0]     ef;
        for (int i = 0; i < 3; i++) begin
            drive_op(ops[i], 32'hAA55F00F, bs[i], 1'b1, 1'b0);
            #1;
            eo = out_q.pop_front();
            vectors++;
            if (vect_out !== eo) begin
                miscompares++;
                $display("FAIL shift%0d vect_out got %h want %h", i, vect_out, eo);
            end
            @(posedge clk); #1;
            ef = flag_q.pop_front();
            vectors++;
            if (NZ_flags !== ef) begin
                miscompares++;
                $display("FAIL shift%0d_flags NZ_flags got %b want %b", i, NZ_flags, ef);
            end
        end
    endtask

    task automatic test_flag_gating();
        logic           ows[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic           pcws[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [2:0]     ops[4]  = '{3'd3, 3'd1, 3'd1, 3'd1};
        logic [N*W-1:0] eo;
        logic [1:0]     ef;
        for (int i = 0; i < 4; i++) begin
            drive_op(ops[i], 32'h33CCAA55, (i == 0) ? 32'h33CCAA55 : 32'hCC3355AA, ows[i], pcws[i]);
            #1;
            eo = out_q.pop_front();
            vectors++;
            if (vect_out !== eo) begin
                miscompares++;
                $display("FAIL gating%0d vect_out got %h want %h", i, vect_out, eo);
            end
            @(posedge clk); #1;
            ef = flag_q.pop_front();
            vectors++;
            if (NZ_flags !== ef) begin
                miscompares++;
                $display("FAIL gating%0d_flags NZ_flags got %b want %b", i, NZ_flags, ef);
            end
        end
    endtask

    task automatic test_mov_pass();
        logic [N*W-1:0] eo;
        drive_op(3'd0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
        #1;
        eo = out_q.pop_front();
        void'(flag_q.pop_front());
        vectors++;
        if (vect_out !== eo || vect_out !== 32'h9ABCDEF0) begin
            miscompares++;
            $display("FAIL mov vect_out got %h want %h", vect_out, eo);
        end
        drive_op(3'd7, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
        #1;
        eo = out_q.pop_front();
        void'(flag_q.pop_front());
        vectors++;
        if (vect_out !== eo || vect_out !== 32'h12345678) begin
            miscompares++;
            $display("FAIL pass vect_out got %h want %h", vect_out, eo);
        end
    endtask

    task automatic test_async_reset();
        logic [N*W-1:0] eo;
        logic [1:0]     ef;
        drive_op(3'd7, 32'hFF00FF00, 32'h0, 1'b1, 1'b0);
        @(posedge clk); #1;
        void'(out_q.pop_front());
        ef = flag_q.pop_front();
        vectors++;
        if (NZ_flags !== ef) begin
            miscompares++;
            $display("FAIL pre_async NZ_flags got %b want %b", NZ_flags, ef);
        end
        @(negedge clk);
        #1 reset = 1'b0;
        flag_model = 2'b00;
        #1;
        vectors++;
        if (NZ_flags !== 2'b00) begin
            miscompares++;
            $display("FAIL async_clear NZ_flags got %b want 00", NZ_flags);
        end
        vect1 = 32'h80402010;
        eo = model(3'd7, vect1, vect2);
        #1;
        vectors++;
        if (vect_out !== eo) begin
            miscompares++;
            $display("FAIL in_reset_vect_out got %h want %h", vect_out, eo);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [N*W-1:0] eo;
        logic [1:0]     ef;
        for (int i = 0; i < 40; i++) begin
            drive_op(3'($urandom_range(0, 7)), {$urandom}, {$urandom},
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
            #1;
            eo = out_q.pop_front();
            vectors++;
            if (vect_out !== eo) begin
                miscompares++;
                $display("FAIL random%0d op=%0d vect_out got %h want %h", i, ExecuteOp, vect_out, eo);
            end
            @(posedge clk); #1;
            ef = flag_q.pop_front();
            vectors++;
            if (NZ_flags !== ef) begin
                miscompares++;
                $display("FAIL random%0d_flags NZ_flags got %b want %b", i, NZ_flags, ef);
            end
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b0;
        ExecuteOp      = 3'd0;
        PCWrEn         = 1'b0;
        overwriteFlags = 1'b0;
        vect1          = '0;
        vect2          = '0;
        flag_model     = 2'b00;
        test_reset();
        test_arith();
        test_shifts();
        test_flag_gating();
        test_mov_pass();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
